// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage of the multi-cycle MIPS core.
// Commits next PC on PCcount and fetches instruction words over req/ack.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCcount,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] addr_imm,
    input  logic [31:0] jr_target,
    input  logic        IR_DR,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] IR,
    output logic        ir_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        misalign
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    logic [1:0]  state;
    logic [31:0] next_pc;

    assign pc_plus4 = pc + PC_STEP;

    always_comb begin
        next_pc = pc_plus4;
        unique case (pc_sel)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + (addr_imm << 2);
            2'b10: next_pc = {pc_plus4[31:28], addr_imm[25:0], 2'b00};
            2'b11: next_pc = {jr_target[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign mem_req  = (state == REQ);
    assign ir_valid = (state == VALID);
    assign busy     = (state != IDLE);
    assign misalign = reset & PCcount & (pc_sel == 2'b11)
                    & (jr_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            IR       <= '0;
            mem_addr <= RESET_PC;
        end else begin
            if (PCcount)
                pc <= next_pc;
            case (state)
                IDLE: begin
                    if (IR_DR) begin
                        state    <= REQ;
                        mem_addr <= PCcount ? next_pc : pc;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        IR    <= mem_rdata;
                        state <= VALID;
                    end
                end
                VALID:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        PCcount;
    logic [1:0]  pc_sel;
    logic [31:0] addr_imm;
    logic [31:0] jr_target;
    logic        IR_DR;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] IR;
    logic        ir_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        misalign;

    int passed = 0;
    int total  = 0;
    int nvalid = 0;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .PCcount   (PCcount),
        .pc_sel    (pc_sel),
        .addr_imm  (addr_imm),
        .jr_target (jr_target),
        .IR_DR     (IR_DR),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .IR        (IR),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .busy      (busy),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (ir_valid) nvalid++;
    endtask

    task automatic commit(input logic [1:0] sel, input logic [31:0] imm,
                          input logic [31:0] jr, input logic mis_exp,
                          input logic [31:0] pc_exp, input string tag);
        PCcount   = 1'b1;
        pc_sel    = sel;
        addr_imm  = imm;
        jr_target = jr;
        #1;
        check({tag, "_mis"}, {31'b0, misalign}, {31'b0, mis_exp});
        tick();
        PCcount = 1'b0;
        #1;
        check({tag, "_pc"}, pc, pc_exp);
    endtask

    initial begin
        reset = 1'b0; PCcount = 1'b0; pc_sel = 2'b00;
        addr_imm = '0; jr_target = '0; IR_DR = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0;
        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_ir", IR, 32'h0);
        check("rst_req", {31'b0, mem_req}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 1: zero-wait fetch
        IR_DR = 1'b1;
        tick();
        IR_DR = 1'b0;
        check("t1_req", {31'b0, mem_req}, 32'h1);
        check("t1_addr", mem_addr, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h2020_0003;
        nvalid = 0;
        tick();
        mem_ack = 1'b0;
        check("t1_ir", IR, 32'h2020_0003);
        check("t1_valid", {31'b0, ir_valid}, 32'h1);
        tick();
        check("t1_vcnt", nvalid, 1);
        check("t1_busy", {31'b0, busy}, 32'h0);

        // 2: three sequential commits then fetch
        commit(2'b00, 32'h0, 32'h0, 1'b0, 32'h4, "t2a");
        commit(2'b00, 32'h0, 32'h0, 1'b0, 32'h8, "t2b");
        commit(2'b00, 32'h0, 32'h0, 1'b0, 32'hC, "t2c");
        check("t2_p4", pc_plus4, 32'h10);
        IR_DR = 1'b1;
        tick();
        IR_DR = 1'b0;
        check("t2_addr", mem_addr, 32'hC);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        tick();

        // 3: branch and jump
        commit(2'b11, 32'h0, 32'h100, 1'b0, 32'h100, "t3jr");
        commit(2'b01, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'hFC, "t3br");
        commit(2'b11, 32'h0, 32'h1000_0000, 1'b0, 32'h1000_0000, "t3jr2");
        commit(2'b10, 32'h0000_0040, 32'h0, 1'b0, 32'h1000_0100, "t3j");

        // 4: misaligned jr and wrap
        commit(2'b11, 32'h0, 32'h203, 1'b1, 32'h200, "t4jr");
        check("t4_misoff", {31'b0, misalign}, 32'h0);
        commit(2'b11, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, "t4set");
        check("t4_p4wrap", pc_plus4, 32'h0);
        commit(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, "t4wrap");

        // 5: same-cycle commit fetches new PC; ack delayed 3 cycles
        PCcount = 1'b1; pc_sel = 2'b00; IR_DR = 1'b1;
        tick();
        PCcount = 1'b0; IR_DR = 1'b0;
        check("t5_pc0", pc, 32'h4);
        check("t5_addr0", mem_addr, 32'h4);
        nvalid = 0;
        for (int i = 0; i < 3; i++) begin
            check("t5_req", {31'b0, mem_req}, 32'h1);
            check("t5_addr", mem_addr, 32'h4);
            if (i == 1) begin
                IR_DR = 1'b1; PCcount = 1'b1;
            end
            tick();
            IR_DR = 1'b0; PCcount = 1'b0;
        end
        check("t5_pc1", pc, 32'h8);
        check("t5_addr1", mem_addr, 32'h4);
        check("t5_ir_hold", IR, 32'h1111_2222);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("t5_ir", IR, 32'hDEAD_BEEF);
        check("t5_valid", {31'b0, ir_valid}, 32'h1);
        tick();
        tick();
        check("t5_vcnt", nvalid, 1);
        check("t5_idle", {31'b0, busy}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        check("t5_ackidle", IR, 32'hDEAD_BEEF);

        // 6: reset mid-fetch
        IR_DR = 1'b1;
        tick();
        IR_DR = 1'b0;
        check("t6_req", {31'b0, mem_req}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_reqdrop", {31'b0, mem_req}, 32'h0);
        check("t6_ir", IR, 32'h0);
        check("t6_pc", pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 1'b0;
        check("t6_late_ir", IR, 32'h0);
        check("t6_late_busy", {31'b0, busy}, 32'h0);
        IR_DR = 1'b1;
        tick();
        IR_DR = 1'b0;
        check("t6_addr", mem_addr, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0042;
        tick();
        mem_ack = 1'b0;
        check("t6_ir2", IR, 32'h0000_0042);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
